instr_fetch: RTL and testbench

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/fetch_pkg.sv | 15 +
 rtl/wait_timer.sv | 42 ++++
 rtl/instr_fetch.sv | 148 ++++++++++++++
 tb/tb_instr_fetch.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch types and parameter defaults.
package fetch_pkg;

    localparam int ADDR_W_DEF   = 32;
    localparam int DATA_W_DEF   = 32;
    localparam int MAX_WAIT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/wait_timer.sv
// Saturating wait counter; tc flags that the next enabled cycle reaches MAX_WAIT.
// No latency beyond the count register; no handshake.
module wait_timer
    import fetch_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Cycles already waited equal MAX_WAIT-1, so one more miss is the timeout.
    assign tc = (cnt_q >= CNT_LAST);

endmodule

// File: rtl/instr_fetch.sv
// Single-outstanding instruction fetch: pc_valid -> mem_req next cycle, mem_ack -> ir_valid next cycle.
// Holds ir until ir_ready; flush discards in-flight data; timeout raises sticky fetch_err.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    input  logic              pc_valid,
    input  logic              flush,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_req,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] ir,
    output logic [ADDR_W-1:0] ir_pc,
    output logic              ir_valid,
    input  logic              ir_ready,
    output logic              pc_inc,
    output logic              fetch_err
);

    fetch_state_e      state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [ADDR_W-1:0] ir_pc_q, ir_pc_d;
    logic              ir_valid_q, ir_valid_d;
    logic              pc_inc_q, pc_inc_d;
    logic              fetch_err_q, fetch_err_d;
    logic              issue;
    logic              tmr_en;
    logic              tmr_tc;

    assign tmr_en = ((state_q == REQ) || (state_q == DROP)) && !mem_ack;

    wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (issue),
        .en    (tmr_en),
        .tc    (tmr_tc)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        ir_d        = ir_q;
        ir_pc_d     = ir_pc_q;
        ir_valid_d  = ir_valid_q;
        pc_inc_d    = 1'b0;
        fetch_err_d = fetch_err_q;
        issue       = 1'b0;

        case (state_q)
            IDLE: begin
                issue = pc_valid && !flush && !fetch_err_q;
            end
            REQ: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                    if (!flush) begin
                        ir_d       = mem_rdata;
                        ir_pc_d    = mem_addr_q;
                        ir_valid_d = 1'b1;
                        pc_inc_d   = 1'b1;
                        state_d    = HOLD;
                    end
                end else if (tmr_tc) begin
                    mem_req_d   = 1'b0;
                    fetch_err_d = 1'b1;
                    state_d     = IDLE;
                end else if (flush) begin
                    state_d = DROP;
                end
            end
            HOLD: begin
                if (flush) begin
                    ir_valid_d = 1'b0;
                    state_d    = IDLE;
                end else if (ir_ready) begin
                    ir_valid_d = 1'b0;
                    state_d    = IDLE;
                    issue      = pc_valid && !fetch_err_q;
                end
            end
            DROP: begin
                // Request must stay up until the memory answers; the data is thrown away.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end else if (tmr_tc) begin
                    mem_req_d   = 1'b0;
                    fetch_err_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (issue) begin
            mem_req_d  = 1'b1;
            mem_addr_d = {pc[ADDR_W-1:2], 2'b00};
            state_d    = REQ;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            ir_q        <= '0;
            ir_pc_q     <= '0;
            ir_valid_q  <= 1'b0;
            pc_inc_q    <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            ir_q        <= ir_d;
            ir_pc_q     <= ir_pc_d;
            ir_valid_q  <= ir_valid_d;
            pc_inc_q    <= pc_inc_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign ir        = ir_q;
    assign ir_pc     = ir_pc_q;
    assign ir_valid  = ir_valid_q;
    assign pc_inc    = pc_inc_q;
    assign fetch_err = fetch_err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic against a transaction-level scoreboard.
module tb_instr_fetch;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] pc;
    logic          pc_valid;
    logic          flush;
    logic [AW-1:0] mem_addr;
    logic          mem_req;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic [DW-1:0] ir;
    logic [AW-1:0] ir_pc;
    logic          ir_valid;
    logic          ir_ready;
    logic          pc_inc;
    logic          fetch_err;

    always #5 clk = ~clk;

    instr_fetch #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_WAIT (MW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pc        (pc),
        .pc_valid  (pc_valid),
        .flush     (flush),
        .mem_addr  (mem_addr),
        .mem_req   (mem_req),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .ir        (ir),
        .ir_pc     (ir_pc),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .pc_inc    (pc_inc),
        .fetch_err (fetch_err)
    );

    int checks = 0;
    int errors = 0;

    // Expected deliveries: {instruction, aligned address}
    logic [63:0] sb_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: transaction-level model of what the fetch unit must deliver.
    logic          rst_seen   = 1'b0;
    logic          rst_prev   = 1'b0;
    logic          prev_req   = 1'b0;
    logic          prev_inc   = 1'b0;
    logic          deliv_prev = 1'b0;
    logic          tainted    = 1'b0;
    logic [AW-1:0] prev_pc    = '0;
    logic [AW-1:0] exp_addr   = '0;

    always @(negedge clk) begin
        logic deliv_now;
        deliv_now = 1'b0;
        if (rst_seen) begin
            if (rst_prev) begin
                chk("reset_outputs_zero",
                    {mem_req, mem_addr, ir, ir_pc, ir_valid, pc_inc, fetch_err}, '0);
            end else begin
                chk("pc_inc_after_delivery", pc_inc, deliv_prev);
                if (pc_inc && prev_inc) chk("pc_inc_not_back_to_back", 1, 0);
                if (mem_req && !prev_req) begin
                    exp_addr = {prev_pc[AW-1:2], 2'b00};
                    chk("mem_addr_on_issue", mem_addr, exp_addr);
                end else if (mem_req) begin
                    chk("mem_addr_stable", mem_addr, exp_addr);
                end
                if (ir_valid) begin
                    if (sb_q.size() == 0) begin
                        chk("ir_valid_without_delivery", 1, 0);
                    end else begin
                        chk("ir_and_ir_pc", {ir, ir_pc}, sb_q[0]);
                        if (ir_ready || flush) void'(sb_q.pop_front());
                    end
                end
            end
            deliv_now = reset && mem_req && mem_ack && !(tainted || flush);
            if (deliv_now) sb_q.push_back({mem_rdata, exp_addr});
            if (!mem_req || mem_ack || !reset) tainted = 1'b0;
            else tainted = tainted || flush;
            if (!reset) sb_q.delete();
        end
        if (!reset) rst_seen = 1'b1;
        rst_prev   = !reset;
        prev_req   = mem_req;
        prev_inc   = pc_inc;
        prev_pc    = pc;
        deliv_prev = deliv_now;
    end

    initial begin
        logic [AW-1:0] pcm;
        int            wait_cnt;

        reset = 1'b0; pc = '0; pc_valid = 1'b0; flush = 1'b0;
        mem_rdata = '0; mem_ack = 1'b0; ir_ready = 1'b0;
        tick();
        tick();
        chk("reset_state", {mem_req, mem_addr, ir, ir_pc, ir_valid, pc_inc, fetch_err}, '0);
        reset = 1'b1;
        tick();

        // Basic fetch, ack after two request cycles
        pc = 32'h100; pc_valid = 1'b1;
        tick();
        chk("basic_mem_req", mem_req, 1);
        chk("basic_mem_addr", mem_addr, 32'h100);
        pc_valid = 1'b0;
        tick();
        chk("basic_req_held", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ack = 1'b0;
        chk("basic_ir", {ir_valid, ir, ir_pc}, {1'b1, 32'hDEADBEEF, 32'h100});
        chk("basic_pc_inc", pc_inc, 1);
        chk("basic_req_drop", mem_req, 0);

        // Back-pressure then back-to-back fetch
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("stall_ir_stable", {ir_valid, ir, ir_pc, pc_inc}, {1'b1, 32'hDEADBEEF, 32'h100, 1'b0});
        end
        ir_ready = 1'b1; pc_valid = 1'b1; pc = 32'h104;
        tick();
        chk("b2b_mem_req", {mem_req, mem_addr, ir_valid}, {1'b1, 32'h104, 1'b0});
        ir_ready = 1'b0; pc_valid = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        tick();
        mem_ack = 1'b0; ir_ready = 1'b1;
        chk("b2b_ir", {ir_valid, ir, ir_pc}, {1'b1, 32'h1111_2222, 32'h104});
        tick();
        ir_ready = 1'b0;
        chk("b2b_ir_taken", ir_valid, 0);

        // Flush with ack pending -> DROP, data discarded
        pc = 32'h200; pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("drop_req_held", {mem_req, pc_inc}, {1'b1, 1'b0});
        tick();
        chk("drop_req_still", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        tick();
        mem_ack = 1'b0;
        chk("drop_done", {mem_req, pc_inc, ir_valid}, 3'b000);
        tick();
        chk("drop_no_ir", {ir_valid, pc_inc}, 2'b00);

        // Flush together with ack -> IDLE
        pc = 32'h300; pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0; flush = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h3333_3333;
        tick();
        flush = 1'b0; mem_ack = 1'b0;
        chk("flush_ack", {mem_req, pc_inc, ir_valid}, 3'b000);

        // Misaligned pc
        pc = 32'h103; pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        chk("misaligned_addr", {mem_req, mem_addr}, {1'b1, 32'h100});
        mem_ack = 1'b1; mem_rdata = 32'h0BADF00D; ir_ready = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("misaligned_ir_pc", {ir_valid, ir_pc}, {1'b1, 32'h100});
        tick();

        // Reset mid-fetch with a late ack
        pc = 32'h400; pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0; reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("reset_mid_fetch", {mem_req, mem_addr, ir, ir_pc, ir_valid, pc_inc, fetch_err}, '0);
        mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        tick();
        mem_ack = 1'b0;
        chk("late_ack_ignored", {mem_req, mem_addr, ir, ir_pc, ir_valid, pc_inc, fetch_err}, '0);
        tick();
        chk("late_ack_no_ir", {ir_valid, pc_inc}, 2'b00);

        // Random traffic; acks always arrive before the timeout
        pcm = 32'h1000;
        wait_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            if (pc_inc) pcm = pcm + 32'd4;
            flush = ($urandom_range(0, 11) == 0);
            if (flush) pcm = $urandom;
            pc = pcm;
            pc_valid = ($urandom_range(0, 3) != 0);
            ir_ready = 1'($urandom_range(0, 1));
            reset = ($urandom_range(0, 249) != 0);
            mem_rdata = $urandom;
            if (mem_req) begin
                wait_cnt++;
                mem_ack = (wait_cnt >= 3) || ($urandom_range(0, 2) == 0);
            end else begin
                wait_cnt = 0;
                mem_ack = ($urandom_range(0, 9) == 0);
            end
            tick();
        end

        // Drain outstanding work
        reset = 1'b1; flush = 1'b0; pc_valid = 1'b0; ir_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            mem_ack = mem_req;
            mem_rdata = $urandom;
            tick();
        end
        mem_ack = 1'b0;
        tick();
        chk("scoreboard_drained", sb_q.size(), 0);

        // Timeout with MAX_WAIT=4
        pc = 32'h500; pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        chk("timeout_req_rise", mem_req, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("timeout_waiting", {fetch_err, mem_req}, 2'b01);
        end
        tick();
        chk("timeout_err", {fetch_err, mem_req, pc_inc}, 3'b100);
        pc = 32'h600; pc_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("err_blocks_fetch", {fetch_err, mem_req}, 2'b10);
        end
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("reset_clears_err", fetch_err, 0);
        tick();
        chk("fetch_after_reset", {mem_req, mem_addr}, {1'b1, 32'h600});
        pc_valid = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D; ir_ready = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk("final_ir", {ir_valid, ir, ir_pc}, {1'b1, 32'hCAFEF00D, 32'h600});
        tick();
        tick();
        chk("final_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
